// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and sizes for the SSD display scheduler
package ssd_pkg;

  localparam int NUM_SRC = 4;
  localparam int VAL_W   = 13;
  localparam int BCD_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_t;

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_bin2bcd_seq.sv
// rtl/ssd_bin2bcd_seq.sv - sequential 13-bit binary to 4-digit BCD converter (shift-add-3)
// SSD_SCHED_HEX_EN: skip the shift phase and report the value as four hex digits.
module ssd_bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  input  logic [1:0]       src_tag,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic [1:0]       bcd_tag
);

  conv_state_t      state;
  conv_state_t      state_nx;
  logic [VAL_W-1:0] shreg;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       step;
  logic [1:0]       tag_q;

  assign bcd_adj = add3_nibbles(bcd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
`ifdef SSD_SCHED_HEX_EN
        state_nx = COMMIT;
`else
        state_nx = SHIFT;
`endif
      end
      SHIFT: begin
        if (step == 4'(VAL_W - 1)) state_nx = COMMIT;
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcd_q <= '0;
      step  <= '0;
      tag_q <= '0;
    end else begin
      case (state)
        LOAD: begin
          tag_q <= src_tag;
          step  <= '0;
`ifdef SSD_SCHED_HEX_EN
          shreg <= '0;
          bcd_q <= {{(BCD_W - VAL_W){1'b0}}, value};
`else
          shreg <= value;
          bcd_q <= '0;
`endif
        end
        SHIFT: begin
          // MSB of the binary shifter enters the ones digit after correction.
          {bcd_q, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
          step           <= step + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == COMMIT);
  assign bcd     = bcd_q;
  assign bcd_tag = tag_q;

endmodule

// File: rtl/ssd_display_scheduler.sv
// rtl/ssd_display_scheduler.sv - round-robin source selection and periodic refresh of a 4-digit SSD
// SSD_SCHED_HEX_EN: display hexadecimal instead of decimal (passed through to the converter).
module ssd_display_scheduler
  import ssd_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int DWELL_TICKS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC*VAL_W-1:0] src_data,
  input  logic                   hold_i,
  input  logic                   next_i,
  output logic [BCD_W-1:0]       digits_o,
  output logic [1:0]             src_idx_o,
  output logic                   busy_o,
  output logic                   upd_o
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  logic [TW-1:0]    tick_cnt;
  logic [DW-1:0]    dwell_cnt;
  logic [1:0]       sel;
  logic [1:0]       sel_nx;
  logic             tick;
  logic             dwell_wrap;
  logic             any_req;
  logic             advance;
  logic             sel_chg;
  logic             conv_req;
  logic             pending;
  logic             start;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [1:0]       conv_tag;
  logic [VAL_W-1:0] sel_val;

  assign tick       = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign dwell_wrap = (dwell_cnt == DW'(DWELL_TICKS - 1));
  assign any_req    = |src_req;
  assign advance    = next_i || (tick && dwell_wrap && !hold_i);

  // Scan from the farthest successor down so the nearest requester wins;
  // the current index is kept when nobody else is asking.
  always_comb begin
    sel_nx = sel;
    if (advance && any_req) begin
      for (int i = NUM_SRC - 1; i >= 1; i--) begin
        if (src_req[sel + 2'(i)]) sel_nx = sel + 2'(i);
      end
    end
  end

  assign sel_chg  = (sel_nx != sel);
  assign conv_req = any_req && (tick || sel_chg);
  assign start    = !conv_busy && any_req && (conv_req || pending);
  assign sel_val  = src_data[sel*VAL_W +: VAL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      dwell_cnt <= '0;
      sel       <= '0;
      pending   <= 1'b0;
      digits_o  <= '0;
      src_idx_o <= '0;
      upd_o     <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (next_i) begin
        dwell_cnt <= '0;
      end else if (tick) begin
        dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + 1'b1;
      end
      sel <= sel_nx;
      // Requests seen while the converter is occupied collapse into one refresh.
      if (start) begin
        pending <= 1'b0;
      end else if (conv_req) begin
        pending <= 1'b1;
      end
      upd_o <= conv_done;
      if (conv_done) begin
        digits_o  <= conv_bcd;
        src_idx_o <= conv_tag;
      end
    end
  end

  ssd_bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .value   (sel_val),
    .src_tag (sel),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .bcd_tag (conv_tag)
  );

  assign busy_o = conv_busy;

endmodule
